imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the instruction memory that the fetch stage reads. It accepts a byte stream with a length header, little-endian 32-bit words and an XOR checksum. It assembles the words and writes them sequentially into the i_cache write port starting at word address 0. It holds the core (fetch and downstream) in reset until a checksum-verified image is in place.

## Interface
- `ADDR_W`, default 11: word-address width; matches fetch indexing pc[12:2].
- `DEPTH`, default 2048: capacity in 32-bit words; must equal 2**ADDR_W.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse that begins a load; sampled only in IDLE, DONE and ERROR.
- `byte_valid`  in  1  source presents a byte.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte; a transfer occurs when valid and ready are both 1.
- `wr_en`  out  1  i_cache write strobe, one cycle per word.
- `wr_addr`  out  ADDR_W  word address for the write.
- `wr_data`  out  32  word to write.
- `cpu_hold`  out  1  drive to the core's rst; 1 keeps fetch in its reset state.
- `done`  out  1  sticky flag: image loaded and checksum good.
- `err`  out  1  sticky flag: checksum mismatch or length greater than DEPTH.
- `words_loaded`  out  ADDR_W+1  count of words written in the current or last load.

## Operation
- **Stream format:**
  - LEN_LO byte, then LEN_HI byte: word count N, 16 bits, little-endian.
  - N×4 payload bytes; each word is sent least-significant byte first.
  - One CHK byte.
  - The checksum is the XOR of all payload bytes only, not the header. The load is good when CHK equals that XOR.
- **State machine:**
  - IDLE: `start` → LEN0.
  - LEN0: on transfer, latch LEN_LO → LEN1.
  - LEN1: on transfer, latch LEN_HI. If N > DEPTH → ERROR. If N = 0 → CHECK. Otherwise → DATA.
  - DATA: on each transfer, shift the byte into the assembly register at lane byte_cnt, XOR it into the checksum, and increment byte_cnt (2 bits, wraps). When lane 3 is accepted, issue a write. After the Nth word is accepted → CHECK.
  - CHECK: on transfer, compare against the accumulated XOR. Match → DONE; mismatch → ERROR.
  - DONE and ERROR: hold. `start` clears `done`, `err`, `words_loaded`, the checksum and the counters, then → LEN0.
- **Per-state outputs:**
  - `byte_ready` = 1 in LEN0, LEN1, DATA and CHECK; 0 otherwise. It does not depend on `byte_valid`.
  - `cpu_hold` = 0 only in DONE; 1 in every other state, including ERROR and during a reload.
- **Write addressing:**
  - `wr_addr` starts at 0 for each load and increments by 1 after each write.
  - `words_loaded` increments with each write. It saturates by construction, because N ≤ DEPTH.
- **Ignored inputs:**
  - `start` in LEN0, LEN1, DATA or CHECK: no effect.
  - A byte offered while `byte_ready` = 0 is not consumed.
- **Asynchronous reset, including mid-load:** state → IDLE; `cpu_hold` = 1; `done` = `err` = 0; `wr_en` = 0; counters and checksum cleared. Words already written stay in memory and are not invalidated.

## Timing
- **Reset values:**
  - `byte_ready` 0, `wr_en` 0, `wr_addr` 0, `wr_data` 0.
  - `cpu_hold` 1, `done` 0, `err` 0, `words_loaded` 0.
- **`start` to first acceptance:** the cycle after `start` is sampled in IDLE, `byte_ready` = 1.
- **Throughput:** one byte per cycle, so a word every 4 cycles at full rate. The source may stall arbitrarily.
- **Write latency:** `wr_en` is a registered pulse in the cycle after the lane-3 transfer. `wr_addr` and `wr_data` are valid in that same cycle. The address advances in the following cycle.
- **Back-to-back words:** a write can coincide with the next word's lane-0 transfer; the assembly register is separate from `wr_data`.
- **Last word into CHECK:**
  - The last-word write pulse is issued in the first CHECK cycle.
  - The CHK byte may transfer in that same cycle.
  - DONE or ERROR is entered only after that write has been issued.
- **Completion:** `done` and `cpu_hold` = 0 take effect together, one cycle after the CHK transfer. The fetch state machine then exits reset and reads word 0.

## Test plan
- **Good 3-word load:** N = 3; words 0x00000013, 0x00100093, 0xDEADBEEF; correct CHK. Expect three `wr_en` pulses at addresses 0, 1, 2 with exactly those words. Then `done` = 1, `cpu_hold` = 0, `words_loaded` = 3.
- **Bad checksum:** same image with CHK ^ 0x01. All three writes still occur; then `err` = 1, `done` = 0, `cpu_hold` stays 1.
- **Boundary lengths:**
  - N = 0 followed by CHK = 0x00: expect `done` with no writes.
  - N = 2049 (0x0801): expect `err` immediately after LEN_HI, no writes, `byte_ready` = 0.
- **Backpressure and ignored start:** random `byte_valid` gaps with a 64-word image; `start` pulsed mid-DATA. Expect data and addresses identical to the gap-free run and `start` ignored.
- **Reset mid-load:** assert `rst_n` low after 2 words of 5. Expect all outputs at their reset values asynchronously. A subsequent `start` with a full 5-word image rewrites from address 0 and reaches `done`.
- **Reload after DONE:** `start` pulse while in DONE. Expect `cpu_hold` back to 1 and `done` cleared the next cycle; the new image loads from address 0.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: takes a length-prefixed, XOR-checksummed byte stream and writes the
// assembled little-endian words into the instruction memory, holding the core until done.
module imem_loader #(
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [7:0]        r_lenLo;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_wordCnt;
    logic [1:0]        r_byteCnt;
    logic [23:0]       r_asm;
    logic [7:0]        r_chk;
    logic              r_wrEn;
    logic [ADDR_W-1:0] r_wrAddr;
    logic [31:0]       r_wrData;
    logic [ADDR_W:0]   r_wordsLoaded;
    logic              r_done;
    logic              r_err;

    logic              w_ready;
    logic              w_xfer;
    logic              w_startOk;
    logic [15:0]       w_lenFull;
    logic              w_lenTooBig;
    logic              w_lenZero;
    logic [ADDR_W:0]   w_wordCntInc;
    logic              w_lastWord;

    assign w_xfer       = byte_valid & w_ready;
    assign w_startOk    = start && (r_state inside {S_IDLE, S_DONE, S_ERROR});
    assign w_lenFull    = {byte_data, r_lenLo};
    assign w_lenTooBig  = {1'b0, w_lenFull} > 17'(DEPTH);
    assign w_lenZero    = (w_lenFull == 16'd0);
    assign w_wordCntInc = r_wordCnt + 1'b1;
    assign w_lastWord   = (r_byteCnt == 2'd3) && (w_wordCntInc == r_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_LEN0;
            S_LEN0:  if (w_xfer) w_next = S_LEN1;
            S_LEN1: begin
                if (w_xfer) begin
                    if (w_lenTooBig)    w_next = S_ERROR;
                    else if (w_lenZero) w_next = S_CHECK;
                    else                w_next = S_DATA;
                end
            end
            S_DATA:  if (w_xfer && w_lastWord) w_next = S_CHECK;
            S_CHECK: begin
                if (w_xfer) w_next = (byte_data == r_chk) ? S_DONE : S_ERROR;
            end
            S_DONE:  if (start) w_next = S_LEN0;
            S_ERROR: if (start) w_next = S_LEN0;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready  = 1'b0;
        cpu_hold = 1'b1;
        case (r_state)
            S_LEN0, S_LEN1, S_DATA, S_CHECK: w_ready = 1'b1;
            S_DONE:                          cpu_hold = 1'b0;
            default:                         ;
        endcase
    end

    // The address and word count advance in the cycle after each write pulse, so the
    // pulse cycle presents the address the word belongs at.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lenLo       <= '0;
            r_len         <= '0;
            r_wordCnt     <= '0;
            r_byteCnt     <= '0;
            r_asm         <= '0;
            r_chk         <= '0;
            r_wrEn        <= 1'b0;
            r_wrAddr      <= '0;
            r_wrData      <= '0;
            r_wordsLoaded <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_wrEn <= 1'b0;
            if (r_wrEn) begin
                r_wrAddr      <= r_wrAddr + 1'b1;
                r_wordsLoaded <= r_wordsLoaded + 1'b1;
            end
            case (r_state)
                S_LEN0: begin
                    if (w_xfer) r_lenLo <= byte_data;
                end
                S_LEN1: begin
                    if (w_xfer) begin
                        r_len <= w_lenFull[ADDR_W:0];
                        if (w_lenTooBig) r_err <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_chk     <= r_chk ^ byte_data;
                        r_byteCnt <= r_byteCnt + 1'b1;
                        case (r_byteCnt)
                            2'd0: r_asm[7:0]   <= byte_data;
                            2'd1: r_asm[15:8]  <= byte_data;
                            2'd2: r_asm[23:16] <= byte_data;
                            default: begin
                                r_wrData  <= {byte_data, r_asm};
                                r_wrEn    <= 1'b1;
                                r_wordCnt <= w_wordCntInc;
                            end
                        endcase
                    end
                end
                S_CHECK: begin
                    if (w_xfer) begin
                        if (byte_data == r_chk) r_done <= 1'b1;
                        else                    r_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_startOk) begin
                r_done        <= 1'b0;
                r_err         <= 1'b0;
                r_wordsLoaded <= '0;
                r_chk         <= '0;
                r_byteCnt     <= '0;
                r_wordCnt     <= '0;
                r_wrAddr      <= '0;
            end
        end
    end

    assign byte_ready   = w_ready;
    assign wr_en        = r_wrEn;
    assign wr_addr      = r_wrAddr;
    assign wr_data      = r_wrData;
    assign done         = r_done;
    assign err          = r_err;
    assign words_loaded = r_wordsLoaded;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected writes, a monitor
// pops and compares on every wr_en pulse.
module tb_imem_loader;

    localparam int ADDR_W = 11;
    localparam int DEPTH  = 2048;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } expWrite_t;

    expWrite_t   expQ[$];
    expWrite_t   monExp;
    logic [31:0] image[$];
    int          checks = 0;
    int          errors = 0;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("wr_addr", 32'(wr_addr), 32'(monExp.addr));
                checkOutput("wr_data", wr_data, monExp.data);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic sendByte(input logic [7:0] b, input int gapPct);
        int waitCycles = 0;
        while (gapPct > 0 && int'($urandom_range(99)) < gapPct) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!byte_ready) begin
            checkOutput("byte_ready_timeout", 32'(byte_ready), 32'd1);
        end else begin
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("ready_after_start", 32'(byte_ready), 32'd1);
        checkOutput("hold_after_start", 32'(cpu_hold), 32'd1);
        checkOutput("done_after_start", 32'(done), 32'd0);
        checkOutput("err_after_start", 32'(err), 32'd0);
        checkOutput("words_after_start", 32'(words_loaded), 32'd0);
    endtask

    task automatic sendWord(input int idx, input int gapPct, input int startAtWord);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) expQ.push_back('{addr: ADDR_W'(idx), data: image[idx]});
            if (idx == startAtWord && k == 1) start = 1'b1;
            sendByte(image[idx][8*k +: 8], gapPct);
            start = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] chk, input int gapPct, input int startAtWord);
        logic [15:0] n;
        n = 16'(image.size());
        pulseStart();
        sendByte(n[7:0], gapPct);
        sendByte(n[15:8], gapPct);
        for (int i = 0; i < image.size(); i++) sendWord(i, gapPct, startAtWord);
        sendByte(chk, gapPct);
    endtask

    task automatic checkResetValues();
        checkOutput("rst_byte_ready", 32'(byte_ready), 32'd0);
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("rst_wr_data", wr_data, 32'd0);
        checkOutput("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_words_loaded", 32'(words_loaded), 32'd0);
    endtask

    task automatic checkFinal(input logic expDone, input int expWords);
        checkOutput("done", 32'(done), 32'(expDone));
        checkOutput("err", 32'(err), 32'(!expDone));
        checkOutput("cpu_hold", 32'(cpu_hold), 32'(!expDone));
        checkOutput("words_loaded", 32'(words_loaded), 32'(expWords));
        checkOutput("pending_writes", 32'(expQ.size()), 32'd0);
    endtask

    function automatic logic [7:0] xorImage();
        logic [7:0] x = 8'h00;
        foreach (image[i]) x = x ^ image[i][7:0] ^ image[i][15:8] ^ image[i][23:16] ^ image[i][31:24];
        return x;
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #12;
        checkResetValues();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] good 3-word load");
        image = '{32'h0000_0013, 32'h0010_0093, 32'hDEAD_BEEF};
        applyStimulus(8'hB2, 0, -1);
        checkFinal(1'b1, 3);

        $display("[TB] bad checksum, reloaded from DONE");
        applyStimulus(8'hB3, 0, -1);
        checkFinal(1'b0, 3);

        $display("[TB] zero-length image");
        image.delete();
        applyStimulus(8'h00, 0, -1);
        checkFinal(1'b1, 0);

        $display("[TB] oversize length 2049");
        pulseStart();
        sendByte(8'h01, 0);
        sendByte(8'h08, 0);
        checkOutput("oversize_err", 32'(err), 32'd1);
        checkOutput("oversize_done", 32'(done), 32'd0);
        checkOutput("oversize_ready", 32'(byte_ready), 32'd0);
        checkOutput("oversize_hold", 32'(cpu_hold), 32'd1);
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        checkOutput("oversize_ready_held", 32'(byte_ready), 32'd0);
        checkOutput("oversize_words", 32'(words_loaded), 32'd0);

        $display("[TB] 64-word image, full rate then with gaps and a stray start");
        image.delete();
        for (int i = 0; i < 64; i++) image.push_back(32'h0102_0304 * 32'(i + 1) ^ 32'hA5C3_0F00);
        applyStimulus(xorImage(), 0, -1);
        checkFinal(1'b1, 64);
        applyStimulus(xorImage(), 40, 20);
        checkFinal(1'b1, 64);

        $display("[TB] reset mid-load then full reload");
        image = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888, 32'h9999_AAAA};
        pulseStart();
        sendByte(8'h05, 0);
        sendByte(8'h00, 0);
        sendWord(0, 0, -1);
        sendWord(1, 0, -1);
        sendByte(image[2][7:0], 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues();
        checkOutput("pending_before_reset", 32'(expQ.size()), 32'd0);
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(xorImage(), 0, -1);
        checkFinal(1'b1, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
